// File: rtl/pwm_pkg.sv
// Constants, state encoding and helper functions shared by the packet-gated
// PWM generator and its measurement counterpart.
package pwm_pkg;

  localparam int SAMPLE_DIV    = 1001;
  localparam int NUM_SAMPLES   = 100;
  localparam int PACKET_SAMPLE = 1666;
  localparam int GAP_SAMPLES   = 101;
  localparam int LOST_SAMPLES  = 3332;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_GAP  = 2'd3
  } meas_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
  endfunction

endpackage

// File: rtl/pwm_in_sampler.sv
// Synchronizes pwm_in, generates the sample tick and provides the current and
// previous sampled levels. Optional 2-of-3 filter: PWM_PACKET_MEAS_GLITCH_FILTER_EN.
module pwm_in_sampler #(
  parameter int SAMPLE_DIV = pwm_pkg::SAMPLE_DIV
) (
  input  logic clk_100m,
  input  logic rst_n,
  input  logic pwm_in,
  output logic s,
  output logic s_prev,
  output logic tick
);
  import pwm_pkg::*;

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic [DIV_W-1:0] div_cnt_r;
  logic             term_s;
  logic             cur_s;
  logic             s_prev_r;
  logic             tick_r;

  assign term_s = (div_cnt_r == DIV_LAST);

  // Input synchronizer and sample-tick divider
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r   <= 1'b1;
      sync2_r   <= 1'b1;
      div_cnt_r <= '0;
      tick_r    <= 1'b0;
      s_prev_r  <= 1'b1;
    end else begin
      sync1_r  <= pwm_in;
      sync2_r  <= sync1_r;
      tick_r   <= term_s;
      if (term_s) begin
        div_cnt_r <= '0;
        s_prev_r  <= cur_s;
      end else begin
        div_cnt_r <= div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
      end
    end
  end

`ifdef PWM_PACKET_MEAS_GLITCH_FILTER_EN
  logic [2:0] hist_r;

  // Three-sample history; the level is their majority
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      hist_r <= 3'b111;
    end else if (term_s) begin
      hist_r <= {hist_r[1:0], sync2_r};
    end
  end

  assign cur_s = maj3(hist_r);
`else
  logic raw_r;

  // Single raw sample per tick
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      raw_r <= 1'b1;
    end else if (term_s) begin
      raw_r <= sync2_r;
    end
  end

  assign cur_s = raw_r;
`endif

  assign s      = cur_s;
  assign s_prev = s_prev_r;
  assign tick   = tick_r;

endmodule

// File: rtl/pwm_packet_meas.sv
// Measures PWM high time, period, burst length, packet period and loss of
// signal on the sample grid. Optional input filter: PWM_PACKET_MEAS_GLITCH_FILTER_EN.
module pwm_packet_meas #(
  parameter int SAMPLE_DIV   = pwm_pkg::SAMPLE_DIV,
  parameter int NUM_SAMPLES  = pwm_pkg::NUM_SAMPLES,
  parameter int GAP_SAMPLES  = pwm_pkg::GAP_SAMPLES,
  parameter int LOST_SAMPLES = pwm_pkg::LOST_SAMPLES
) (
  input  logic        clk_100m,
  input  logic        rst_n,
  input  logic        pwm_in,
  output logic [7:0]  pwm_high,
  output logic [7:0]  pwm_period,
  output logic        pwm_valid,
  output logic [10:0] burst_len,
  output logic [10:0] packet_period,
  output logic        packet_valid,
  output logic        sig_lost
);
  import pwm_pkg::*;

  // A gap no longer than a nominal period would split normal cycles into bursts
  localparam int GAP_EFF = (GAP_SAMPLES > NUM_SAMPLES) ? GAP_SAMPLES : NUM_SAMPLES + 1;
  localparam logic [11:0] GAP_CNT  = 12'(GAP_EFF);
  localparam logic [11:0] LOST_CNT = 12'(LOST_SAMPLES);

  logic        s_s, s_prev_s, tick_s;
  logic        rise_s, fall_s, lost_s;
  meas_state_t state_r;
  logic [7:0]  hi_cnt_r, per_cnt_r;
  logic [10:0] burst_cnt_r, burst_end_r, pkt_cnt_r;
  logic [11:0] low_run_r, no_edge_r;
  logic        have_pkt_r;

  pwm_in_sampler #(.SAMPLE_DIV(SAMPLE_DIV)) u_sampler (
    .clk_100m (clk_100m),
    .rst_n    (rst_n),
    .pwm_in   (pwm_in),
    .s        (s_s),
    .s_prev   (s_prev_s),
    .tick     (tick_s)
  );

  assign rise_s = tick_s & s_s & ~s_prev_s;
  assign fall_s = tick_s & ~s_s & s_prev_s;
  assign lost_s = tick_s & ~rise_s & (sat_inc12(no_edge_r) == LOST_CNT);

  // Measurement FSM, counters and registered outputs
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      hi_cnt_r      <= 8'd0;
      per_cnt_r     <= 8'd0;
      burst_cnt_r   <= 11'd0;
      burst_end_r   <= 11'd0;
      pkt_cnt_r     <= 11'd0;
      low_run_r     <= 12'd0;
      no_edge_r     <= 12'd0;
      have_pkt_r    <= 1'b0;
      pwm_high      <= 8'd0;
      pwm_period    <= 8'd0;
      pwm_valid     <= 1'b0;
      burst_len     <= 11'd0;
      packet_period <= 11'd0;
      packet_valid  <= 1'b0;
      sig_lost      <= 1'b1;
    end else begin
      pwm_valid    <= 1'b0;
      packet_valid <= 1'b0;
      if (tick_s) begin
        if (rise_s) begin
          no_edge_r <= 12'd0;
          sig_lost  <= 1'b0;
        end else begin
          no_edge_r <= sat_inc12(no_edge_r);
        end
        if (lost_s) begin
          sig_lost      <= 1'b1;
          pwm_high      <= 8'd0;
          pwm_period    <= 8'd0;
          burst_len     <= 11'd0;
          packet_period <= 11'd0;
          have_pkt_r    <= 1'b0;
          state_r       <= ST_IDLE;
        end else begin
          if (state_r != ST_IDLE) begin
            pkt_cnt_r <= sat_inc11(pkt_cnt_r);
          end
          case (state_r)
            ST_IDLE: begin
              if (rise_s) begin
                hi_cnt_r    <= 8'd1;
                per_cnt_r   <= 8'd1;
                burst_cnt_r <= 11'd1;
                pkt_cnt_r   <= 11'd1;
                state_r     <= ST_HIGH;
              end
            end
            ST_HIGH: begin
              per_cnt_r   <= sat_inc8(per_cnt_r);
              burst_cnt_r <= sat_inc11(burst_cnt_r);
              if (fall_s) begin
                burst_end_r <= burst_cnt_r;
                low_run_r   <= 12'd1;
                state_r     <= ST_LOW;
              end else begin
                hi_cnt_r <= sat_inc8(hi_cnt_r);
              end
            end
            ST_LOW: begin
              burst_cnt_r <= sat_inc11(burst_cnt_r);
              if (rise_s) begin
                pwm_high   <= hi_cnt_r;
                pwm_period <= per_cnt_r;
                pwm_valid  <= 1'b1;
                hi_cnt_r   <= 8'd1;
                per_cnt_r  <= 8'd1;
                low_run_r  <= 12'd0;
                state_r    <= ST_HIGH;
              end else begin
                per_cnt_r <= sat_inc8(per_cnt_r);
                low_run_r <= sat_inc12(low_run_r);
                // The unfinished last cycle of the burst is dropped here
                if (sat_inc12(low_run_r) == GAP_CNT) begin
                  burst_len <= burst_end_r;
                  state_r   <= ST_GAP;
                end
              end
            end
            ST_GAP: begin
              if (rise_s) begin
                if (have_pkt_r) begin
                  packet_period <= pkt_cnt_r;
                end
                have_pkt_r   <= 1'b1;
                packet_valid <= 1'b1;
                pkt_cnt_r    <= 11'd1;
                hi_cnt_r     <= 8'd1;
                per_cnt_r    <= 8'd1;
                burst_cnt_r  <= 11'd1;
                state_r      <= ST_HIGH;
              end
            end
            default: state_r <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/pwm_packet_meas.md
# pwm_packet_meas

Receive-side counterpart of the packet-gated PWM generator. It samples an incoming PWM line on the same 100 kHz sample grid and measures the following quantities in sample units:
- per-cycle high time and period;
- burst (packet-on) length;
- packet repetition period;
- loss of signal.

It sits on the bench/loopback side of the 4MB board, so generated waveforms can be checked in hardware and shown on HEX displays.

## Interface
- SAMPLE_DIV, 1001: system clocks per sample tick. Matches the generator's tick spacing: count 0..SAMPLE_FREQ inclusive.
- NUM_SAMPLES, 100: nominal samples per PWM period.
- GAP_SAMPLES, 101: consecutive low samples that close a burst. Must be greater than NUM_SAMPLES.
- LOST_SAMPLES, 3332: samples without any rising edge before signal-lost is declared.
- clk_100m  in  1  system clock, 100 MHz.
- rst_n  in  1  reset; asynchronous, active-low.
- pwm_in  in  1  asynchronous PWM line under measurement.
- pwm_high  out  8  high samples of the last completed PWM cycle, saturating at 255.
- pwm_period  out  8  samples rising-to-rising of the last completed cycle, saturating at 255.
- pwm_valid  out  1  one-clock pulse when pwm_high/pwm_period update.
- burst_len  out  11  samples from the first rise of a burst to its last fall, saturating at 2047.
- packet_period  out  11  samples between first rises of consecutive bursts, saturating at 2047.
- packet_valid  out  1  one-clock pulse when burst_len/packet_period update.
- sig_lost  out  1  level; high while no rising edge has been seen within LOST_SAMPLES.

## Operation
**Input conditioning**
- pwm_in passes through a 2-FF synchronizer.
- A divider counts 0..SAMPLE_DIV-1 and produces `tick` on the terminal count.
- All measurement logic advances only on `tick`. The sampled level is `s`; the previous sampled level is `s_prev`, which resets to 1, so a line already high at reset is not treated as an edge.
- Rise = s & ~s_prev. Fall = ~s & s_prev.

**State machine**, states IDLE, HIGH, LOW, GAP:
- IDLE (reset state): wait for a rise. On a rise go to HIGH; clear hi_cnt and per_cnt to 1; clear burst_cnt to 1.
- HIGH: on each tick hi_cnt++ and per_cnt++, and burst_cnt++. On a fall go to LOW and latch burst_end = burst_cnt.
- LOW: on each tick per_cnt++, burst_cnt++ and low_run++.
  - On a rise: pwm_high <= hi_cnt, pwm_period <= per_cnt, pulse pwm_valid. Restart hi_cnt and per_cnt at 1, clear low_run, go to HIGH.
  - When low_run reaches GAP_SAMPLES: burst_len <= burst_end and go to GAP. The final cycle of the burst is not reported.
- GAP: pkt_cnt keeps counting.
  - On a rise: packet_period <= pkt_cnt, pulse packet_valid, restart pkt_cnt, hi_cnt, per_cnt and burst_cnt at 1, go to HIGH.
  - The first burst after reset or after sig_lost updates burst_len but not packet_period. packet_valid still pulses.
- pkt_cnt runs from the first rise of each burst in all states except IDLE.

**Loss of signal**
- no_edge_cnt (12 bit) clears on every rise and otherwise increments per tick.
- At LOST_SAMPLES: sig_lost = 1, all measurement outputs clear to 0, FSM goes to IDLE.
- sig_lost clears on the next rise.

**Arithmetic**
- All counters saturate; none wrap.
- A rise and a terminal count on the same tick resolve in favour of the rise.

## Timing
- Output reset values: pwm_high, pwm_period, burst_len and packet_period are 0; pwm_valid and packet_valid are 0; sig_lost is 1.
- Input-to-sample latency: 2 clocks of synchronizer plus up to SAMPLE_DIV clocks of tick alignment.
- Measurement outputs and valid pulses register 1 clock after the deciding tick. Valid pulses are exactly 1 clock wide, with at most one pulse of each kind per tick.
- Reset mid-burst abandons all partial counts. No valid pulse may follow until a fresh rise is seen.

## Configuration
- PWM_PACKET_MEAS_GLITCH_FILTER_EN defined: `s` is the 2-of-3 majority of the last three raw samples, with the sample history resetting to 111. This adds 1 tick of latency; isolated single-sample pulses and dropouts are ignored.
- Macro undefined: `s` is the raw sample, and every single-sample pulse counts.

## Structure
- Shared package pwm_pkg holds SAMPLE_DIV, NUM_SAMPLES, PACKET_SAMPLE (1666), the default GAP/LOST values and the state encoding typedef, so they stay common with the generator.
- Sub-module pwm_in_sampler contains the synchronizer, tick divider and optional glitch filter. It outputs `s`, `s_prev` and `tick`.

## Test plan
- Duty 50 of 100, continuous with no gaps: from the second cycle, pwm_valid every 100 ticks with pwm_high=50 and pwm_period=100; packet_valid never pulses.
- Generator packets of 833 samples on, 1666 period, duty 30: pwm_high=30 and pwm_period=100 inside bursts; burst_len and packet_period read consistent values (±1) each packet; packet_valid once per 1666 ticks.
- Line held low for 3332 ticks after activity: sig_lost rises and all outputs read 0. The next rise clears sig_lost, and no pwm_valid pulse occurs before a second rise.
- Single-sample high glitch in the low phase at duty 50: with the macro, pwm_high stays 50; without it, a short cycle is reported, e.g. pwm_high=1.
- Input high for 300 samples: pwm_high saturates at 255.
- rst_n asserted mid-HIGH: all outputs return to their reset values immediately, with no valid pulse until a new rise.
